// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR and trap unit:
// CSR addresses, cause codes, funct3 opcodes and mstatus bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MCNTINH   = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [4:0] EXC_INSN_MISALIGN = 5'd0;
    localparam logic [4:0] EXC_INSN_FAULT    = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL_INSN  = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT    = 5'd3;
    localparam logic [4:0] EXC_ECALL_M       = 5'd11;

    localparam logic [4:0] IRQ_M_SW       = 5'd3;
    localparam logic [4:0] IRQ_M_TIMER    = 5'd7;
    localparam logic [4:0] IRQ_M_EXT      = 5'd11;
    localparam int         IRQ_LOCAL_BASE = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

    typedef enum logic [2:0] {
        CSR_OP_NONE = 3'b000,
        CSR_OP_RW   = 3'b001,
        CSR_OP_RS   = 3'b010,
        CSR_OP_RC   = 3'b011,
        CSR_OP_RWI  = 3'b101,
        CSR_OP_RSI  = 3'b110,
        CSR_OP_RCI  = 3'b111
    } csr_op_e;

endpackage

// File: rtl/csr_counter.sv
// Free-running event counter with inhibit and 32-bit half write ports.
// A half write takes precedence over the increment; the other half holds.
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inhibit,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 step;

    assign step   = inc & ~inhibit;
    assign cnt_lo = cnt_q[31:0];

    generate
        if (CNT_WIDTH > 32) begin : g_wide
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (we_lo) begin
                    cnt_q[31:0] <= wdata;
                end else if (we_hi) begin
                    cnt_q[CNT_WIDTH-1:32] <= wdata;
                end else if (step) begin
                    cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            assign cnt_hi = cnt_q[CNT_WIDTH-1:32];
        end else begin : g_narrow
            logic unused_we_hi;
            assign unused_we_hi = we_hi;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (we_lo) begin
                    cnt_q <= wdata;
                end else if (step) begin
                    cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            assign cnt_hi = '0;
        end
    endgenerate

endmodule

// File: rtl/csr_mtrap.sv
// Machine-mode CSR file and trap unit with local interrupts and counters.
// Define CSR_VECTORED_EN to store mtvec MODE=01 and vector interrupts.
module csr_mtrap
    import csr_pkg::*;
#(
    parameter logic [31:0] HARTID        = 32'd0,
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter int          CNT_WIDTH     = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     retire,
    input  logic                     trap_valid,
    input  logic [4:0]               trap_cause,
    input  logic [31:0]              trap_tval,
    input  logic [31:0]              trap_pc,
    input  logic                     irq_take,
    input  logic                     mret,
    input  logic                     irq_ext,
    input  logic                     irq_timer,
    input  logic                     irq_sw,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
    input  logic                     csr_we,
    input  logic [2:0]               csr_funct3,
    input  logic [11:0]              csr_addr,
    input  logic [31:0]              csr_rs1,
    input  logic [4:0]               csr_zimm,
    output logic [31:0]              csr_rdata,
    output logic                     csr_illegal,
    output logic                     irq_pending,
    output logic [31:0]              trap_vector,
    output logic [31:0]              mepc_out
);

    localparam logic [31:0] LOCAL_MASK =
        ((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << IRQ_LOCAL_BASE;
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888 | LOCAL_MASK;

    logic        st_mie_q;
    logic        st_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mip_d;
    logic [29:0] mtvec_base_q;
    logic        mtvec_vec;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mscratch_q;
    logic        inh_cy_q;
    logic        inh_ir_q;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

    logic [31:0] mstatus_rd;
    logic [31:0] pend;
    logic [4:0]  irq_cause;
    logic        is_irq;
    logic        trap_entry;
    logic        do_mret;

    csr_op_e     op;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        wr_occurs;
    logic        impl;
    logic        csr_wr;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};

    always_comb begin
        mip_d = '0;
        mip_d[IRQ_M_SW]    = irq_sw;
        mip_d[IRQ_M_TIMER] = irq_timer;
        mip_d[IRQ_M_EXT]   = irq_ext;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mip_d[IRQ_LOCAL_BASE + i] = irq_local[i];
        end
    end

    assign pend        = mip_q & mie_q;
    assign irq_pending = st_mie_q & (|pend);

    // Lowest local index wins among locals; ext > sw > timer override them.
    always_comb begin
        irq_cause = '0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (pend[IRQ_LOCAL_BASE + i]) begin
                irq_cause = 5'(IRQ_LOCAL_BASE + i);
            end
        end
        if (pend[IRQ_M_TIMER]) irq_cause = IRQ_M_TIMER;
        if (pend[IRQ_M_SW])    irq_cause = IRQ_M_SW;
        if (pend[IRQ_M_EXT])   irq_cause = IRQ_M_EXT;
    end

    assign is_irq     = ~trap_valid & irq_take & irq_pending;
    assign trap_entry = trap_valid | is_irq;
    assign do_mret    = mret & ~trap_entry;

    assign op  = csr_op_e'(csr_funct3);
    assign src = csr_funct3[2] ? {27'b0, csr_zimm} : csr_rs1;

    always_comb begin
        wr_occurs = 1'b0;
        wdata     = csr_rdata;
        unique case (op)
            CSR_OP_RW, CSR_OP_RWI: begin
                wr_occurs = 1'b1;
                wdata     = src;
            end
            CSR_OP_RS, CSR_OP_RSI: begin
                wr_occurs = |src;
                wdata     = csr_rdata | src;
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                wr_occurs = |src;
                wdata     = csr_rdata & ~src;
            end
            default: begin
                wr_occurs = 1'b0;
                wdata     = csr_rdata;
            end
        endcase
    end

    always_comb begin
        csr_rdata = '0;
        impl      = 1'b1;
        unique case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_rd;
            CSR_MISA:      csr_rdata = MISA_RV32I;
            CSR_MIE:       csr_rdata = mie_q;
            CSR_MTVEC:     csr_rdata = {mtvec_base_q, 1'b0, mtvec_vec};
            CSR_MCNTINH:   csr_rdata = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
            CSR_MIP:       csr_rdata = mip_q;
            CSR_MCYCLE,
            CSR_CYCLE:     csr_rdata = cyc_lo;
            CSR_MINSTRET,
            CSR_INSTRET:   csr_rdata = ins_lo;
            CSR_MCYCLEH,
            CSR_CYCLEH:    csr_rdata = cyc_hi;
            CSR_MINSTRETH,
            CSR_INSTRETH:  csr_rdata = ins_hi;
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:    csr_rdata = '0;
            CSR_MHARTID:   csr_rdata = HARTID;
            default:       impl      = 1'b0;
        endcase
    end

    assign csr_illegal = csr_we &
        (~impl | ((csr_addr[11:10] == 2'b11) & wr_occurs));

    // Trap and mret both outrank a CSR write committing in the same cycle.
    assign csr_wr = csr_we & ~csr_illegal & wr_occurs & ~trap_entry & ~mret;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st_mie_q  <= 1'b0;
            st_mpie_q <= 1'b0;
        end else if (trap_entry) begin
            st_mpie_q <= st_mie_q;
            st_mie_q  <= 1'b0;
        end else if (do_mret) begin
            st_mie_q  <= st_mpie_q;
            st_mpie_q <= 1'b1;
        end else if (csr_wr && csr_addr == CSR_MSTATUS) begin
            st_mie_q  <= wdata[MSTATUS_MIE];
            st_mpie_q <= wdata[MSTATUS_MPIE];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap_entry) begin
            mepc_q   <= trap_pc & ~32'h3;
            mcause_q <= is_irq ? {1'b1, 26'b0, irq_cause}
                               : {27'b0, trap_cause};
            mtval_q  <= is_irq ? 32'h0 : trap_tval;
        end else if (csr_wr) begin
            if (csr_addr == CSR_MEPC)   mepc_q   <= wdata & ~32'h3;
            if (csr_addr == CSR_MCAUSE) mcause_q <= wdata;
            if (csr_addr == CSR_MTVAL)  mtval_q  <= wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_base_q <= '0;
            mscratch_q   <= '0;
            inh_cy_q     <= 1'b0;
            inh_ir_q     <= 1'b0;
        end else begin
            mip_q <= mip_d;
            if (csr_wr) begin
                unique case (csr_addr)
                    CSR_MIE:      mie_q        <= wdata & IRQ_MASK;
                    CSR_MTVEC:    mtvec_base_q <= wdata[31:2];
                    CSR_MSCRATCH: mscratch_q   <= wdata;
                    CSR_MCNTINH: begin
                        inh_cy_q <= wdata[0];
                        inh_ir_q <= wdata[2];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_VECTORED_EN
    logic mtvec_vec_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_vec_q <= 1'b0;
        end else if (csr_wr && csr_addr == CSR_MTVEC) begin
            mtvec_vec_q <= (wdata[1:0] == 2'b01);
        end
    end

    assign mtvec_vec   = mtvec_vec_q;
    assign trap_vector = (mtvec_vec_q & ~trap_valid & irq_pending)
        ? {mtvec_base_q, 2'b00} + {25'b0, irq_cause, 2'b00}
        : {mtvec_base_q, 2'b00};
`else
    assign mtvec_vec   = 1'b0;
    assign trap_vector = {mtvec_base_q, 2'b00};
`endif

    assign mepc_out = mepc_q;

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk_in),
        .rst_n   (rst_n),
        .inhibit (inh_cy_q),
        .inc     (1'b1),
        .we_lo   (csr_wr && csr_addr == CSR_MCYCLE),
        .we_hi   (csr_wr && csr_addr == CSR_MCYCLEH),
        .wdata   (wdata),
        .cnt_lo  (cyc_lo),
        .cnt_hi  (cyc_hi)
    );

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk_in),
        .rst_n   (rst_n),
        .inhibit (inh_ir_q),
        .inc     (retire),
        .we_lo   (csr_wr && csr_addr == CSR_MINSTRET),
        .we_hi   (csr_wr && csr_addr == CSR_MINSTRETH),
        .wdata   (wdata),
        .cnt_lo  (ins_lo),
        .cnt_hi  (ins_hi)
    );

endmodule

// File: tb/tb_csr_mtrap.sv
// Directed scoreboard bench for the machine-mode CSR and trap unit.
// Expectations follow CSR_VECTORED_EN when the build defines it.
module tb_csr_mtrap;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        retire;
    logic        trap_valid;
    logic [4:0]  trap_cause;
    logic [31:0] trap_tval;
    logic [31:0] trap_pc;
    logic        irq_take;
    logic        mret;
    logic        irq_ext, irq_timer, irq_sw;
    logic [3:0]  irq_local;
    logic        csr_we;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rs1;
    logic [4:0]  csr_zimm;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        irq_pending;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] cyc;

    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
    localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

`ifdef CSR_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    csr_mtrap #(
        .HARTID(32'd5), .NUM_LOCAL_IRQ(4), .CNT_WIDTH(64)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .retire(retire),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_pc(trap_pc),
        .irq_take(irq_take), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .irq_local(irq_local),
        .csr_we(csr_we), .csr_funct3(csr_funct3), .csr_addr(csr_addr),
        .csr_rs1(csr_rs1), .csr_zimm(csr_zimm),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .irq_pending(irq_pending), .trap_vector(trap_vector),
        .mepc_out(mepc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic rd_chk(input logic [11:0] a, input string tag,
                          input logic [31:0] v);
        expect_val(tag, v);
        csr_addr = a;
        #1;
        check(csr_rdata);
    endtask

    task automatic csrw(input logic [11:0] a, input logic [2:0] f3,
                        input logic [31:0] v, input logic [4:0] z);
        csr_we     = 1'b1;
        csr_addr   = a;
        csr_funct3 = f3;
        csr_rs1    = v;
        csr_zimm   = z;
        tick();
        csr_we   = 1'b0;
        csr_rs1  = '0;
        csr_zimm = '0;
    endtask

    initial begin
        rst_n = 1'b0; retire = 0; trap_valid = 0; trap_cause = 0;
        trap_tval = 0; trap_pc = 0; irq_take = 0; mret = 0;
        irq_ext = 0; irq_timer = 0; irq_sw = 0; irq_local = 0;
        csr_we = 0; csr_funct3 = 0; csr_addr = 0; csr_rs1 = 0; csr_zimm = 0;
        repeat (2) @(posedge clk_in);
        #1;
        expect_val("rst_trap_vector", 32'h0); check(trap_vector);
        expect_val("rst_irq_pending", 32'h0); check({31'b0, irq_pending});
        expect_val("rst_mepc_out", 32'h0);    check(mepc_out);
        rst_n = 1'b1;
        tick();
        rd_chk(12'h300, "rst_mstatus", 32'h0000_1800);
        rd_chk(12'h301, "misa", 32'h4000_0100);
        rd_chk(12'hF14, "mhartid", 32'h5);
        rd_chk(12'h304, "rst_mie", 32'h0);

        // Asynchronous reset in the middle of a count
        csrw(12'h305, RW, 32'h3000, 5'd0);
        csrw(12'h300, RS, 32'h8, 5'd0);
        csrw(12'hB00, RW, 32'h1234, 5'd0);
        rd_chk(12'hB00, "mcycle_written", 32'h1234);
        rst_n = 1'b0;
        rd_chk(12'hB00, "async_rst_mcycle", 32'h0);
        rd_chk(12'h300, "async_rst_mstatus", 32'h0000_1800);
        expect_val("async_rst_trap_vector", 32'h0); check(trap_vector);
        rst_n = 1'b1;
        tick();

        // Timer + external together, external wins
        csrw(12'h304, RW, 32'h888, 5'd0);
        csrw(12'h300, RS, 32'h8, 5'd0);
        irq_timer = 1; irq_ext = 1;
        #1;
        expect_val("irq_pending_latency", 32'h0); check({31'b0, irq_pending});
        tick();
        expect_val("irq_pending_set", 32'h1); check({31'b0, irq_pending});
        rd_chk(12'h344, "mip_ext_timer", 32'h880);
        irq_take = 1; trap_pc = 32'h100;
        #1;
        expect_val("tv_base_zero", 32'h0); check(trap_vector);
        tick();
        irq_take = 0;
        rd_chk(12'h342, "mcause_ext", 32'h8000_000B);
        rd_chk(12'h341, "mepc_irq", 32'h100);
        rd_chk(12'h300, "mstatus_after_irq", 32'h0000_1880);
        expect_val("mepc_out_irq", 32'h100); check(mepc_out);
        expect_val("pending_masked", 32'h0); check({31'b0, irq_pending});
        mret = 1;
        tick();
        mret = 0;
        rd_chk(12'h300, "mstatus_after_mret", 32'h0000_1888);
        expect_val("pending_after_mret", 32'h1); check({31'b0, irq_pending});

        // Vectored timer interrupt and mtvec WARL
        irq_ext = 0;
        tick();
        csrw(12'h305, RW, 32'h2001, 5'd0);
        rd_chk(12'h305, "mtvec_mode01", VEC ? 32'h2001 : 32'h2000);
        irq_take = 1; trap_pc = 32'h206;
        #1;
        expect_val("tv_timer", VEC ? 32'h201C : 32'h2000); check(trap_vector);
        tick();
        irq_take = 0; irq_timer = 0;
        rd_chk(12'h342, "mcause_timer", 32'h8000_0007);
        rd_chk(12'h341, "mepc_aligned", 32'h204);
        csrw(12'h305, RW, 32'h2003, 5'd0);
        rd_chk(12'h305, "mtvec_mode11", 32'h2000);
        expect_val("tv_base", 32'h2000); check(trap_vector);

        // Immediate and register set/clear forms
        csrw(12'h340, RWI, 32'h0, 5'h15);
        rd_chk(12'h340, "mscratch_rwi", 32'h15);
        csrw(12'h340, RCI, 32'h0, 5'h05);
        rd_chk(12'h340, "mscratch_rci", 32'h10);
        csrw(12'h340, RS, 32'h100, 5'd0);
        csrw(12'h340, RC, 32'h10, 5'd0);
        rd_chk(12'h340, "mscratch_rs_rc", 32'h100);

        // Illegal accesses
        csr_we = 1; csr_funct3 = RS; csr_addr = 12'hC00; csr_rs1 = 0;
        #1;
        expect_val("ill_ro_nowrite", 32'h0); check({31'b0, csr_illegal});
        csr_rs1 = 1;
        #1;
        expect_val("ill_ro_write", 32'h1); check({31'b0, csr_illegal});
        csr_addr = 12'hC02;
        #1;
        expect_val("ill_instret_write", 32'h1); check({31'b0, csr_illegal});
        tick();
        csr_we = 0; csr_rs1 = 0;
        rd_chk(12'hC02, "instret_unchanged", 32'h0);
        csr_we = 1; csr_funct3 = RW; csr_addr = 12'h7C0;
        #1;
        expect_val("ill_unimpl", 32'h1); check({31'b0, csr_illegal});
        csr_we = 0;
        #1;
        expect_val("ill_needs_we", 32'h0); check({31'b0, csr_illegal});

        // Exception outranks a concurrent mepc write
        trap_valid = 1; trap_cause = 5'd2; trap_tval = 32'hDEAD;
        trap_pc = 32'h303;
        csr_we = 1; csr_funct3 = RW; csr_addr = 12'h341; csr_rs1 = 32'h40;
        #1;
        expect_val("tv_exception", 32'h2000); check(trap_vector);
        tick();
        trap_valid = 0; csr_we = 0; csr_rs1 = 0;
        rd_chk(12'h341, "mepc_exc", 32'h300);
        rd_chk(12'h342, "mcause_exc", 32'h2);
        rd_chk(12'h343, "mtval_exc", 32'hDEAD);
        rd_chk(12'h300, "mstatus_exc", 32'h0000_1800);

        // Counter inhibit, write priority and carry into the high half
        csrw(12'h320, RW, 32'hFFFF_FFFF, 5'd0);
        rd_chk(12'h320, "mcountinhibit", 32'h5);
        csr_addr = 12'hB00;
        #1;
        cyc = csr_rdata;
        retire = 1;
        repeat (10) tick();
        retire = 0;
        rd_chk(12'hB00, "mcycle_frozen", cyc);
        rd_chk(12'hB02, "minstret_frozen", 32'h0);
        csrw(12'h320, RW, 32'h0, 5'd0);
        retire = 1;
        csrw(12'hB02, RW, 32'hFFFF_FFFF, 5'd0);
        rd_chk(12'hB02, "minstret_write_wins", 32'hFFFF_FFFF);
        tick();
        retire = 0;
        rd_chk(12'hB02, "minstret_wrap", 32'h0);
        rd_chk(12'hB82, "minstreth_carry", 32'h1);
        rd_chk(12'hC82, "instreth_shadow", 32'h1);
        csr_addr = 12'hB00;
        #1;
        cyc = csr_rdata;
        tick();
        rd_chk(12'hB00, "mcycle_step", cyc + 32'h1);

        // mip is read-only; local interrupts and mtval clear
        csrw(12'h344, RW, 32'hFFFF_FFFF, 5'd0);
        rd_chk(12'h344, "mip_ignores_write", 32'h0);
        csrw(12'h304, RW, 32'hFFFF_FFFF, 5'd0);
        rd_chk(12'h304, "mie_mask", 32'h000F_0888);
        csrw(12'h300, RSI, 32'h0, 5'h08);
        irq_local = 4'b0110;
        tick();
        rd_chk(12'h344, "mip_local", 32'h0006_0000);
        expect_val("pending_local", 32'h1); check({31'b0, irq_pending});
        irq_take = 1; trap_pc = 32'h500;
        tick();
        irq_take = 0; irq_local = 0;
        rd_chk(12'h342, "mcause_local", 32'h8000_0011);
        rd_chk(12'h343, "mtval_irq", 32'h0);
        rd_chk(12'h341, "mepc_local", 32'h500);

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0",
                   exp_q.size());
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
